// File: rtl/icache_direct_if.sv
// Signal bundle between icache_direct, the instruction fetcher and the memory controller word port.
// Handshakes: start_fetch is a level request held until the one-cycle fetch_ready pulse;
// mem_req is held with a stable mem_addr until the one-cycle mem_ready pulse.
interface icache_direct_if;
    logic        rob_clear_up;
    logic [31:0] pc;
    logic        start_fetch;
    logic        fetch_ready;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;

    modport slave (
        input  rob_clear_up, pc, start_fetch, mem_ready, mem_data,
        output fetch_ready, inst, inst_addr, mem_req, mem_addr
    );

    modport master (
        output rob_clear_up, pc, start_fetch, mem_ready, mem_data,
        input  fetch_ready, inst, inst_addr, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped one-word-per-line instruction cache between the fetcher and the memory word port.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt counters.
module icache_direct #(
    parameter int INDEX_BITS = 6
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    icache_direct_if.slave bus,
`ifdef ICACHE_STATS_EN
    output logic [31:0]    hit_cnt,
    output logic [31:0]    miss_cnt,
`endif
    output logic [1:0]     dbg_state_o
);
    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_WAIT = 2'd1,
        DRAIN     = 2'd2
    } state_e;

    state_e              state_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];
    logic [29:0]         pc_q;
    logic                fetch_ready_q;
    logic [31:0]         inst_q;
    logic [31:0]         inst_addr_q;
    logic                mem_req_q;
    logic [31:0]         mem_addr_q;

    logic [INDEX_BITS-1:0] req_idx;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  lookup_hit;
    logic                  accept;
    logic                  fill;
    logic                  unused_pc_bits;

    assign req_idx        = bus.pc[INDEX_BITS+1:2];
    assign req_tag        = bus.pc[31:INDEX_BITS+2];
    assign fill_idx       = pc_q[INDEX_BITS-1:0];
    assign fill_tag       = pc_q[29:INDEX_BITS];
    assign unused_pc_bits = ^bus.pc[1:0];

    // fetch_ready_q blocks re-serving the stale pc while the fetcher still holds start_fetch.
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign accept     = (state_q == IDLE) && bus.start_fetch && !bus.rob_clear_up && !fetch_ready_q;
    assign fill       = (state_q != IDLE) && bus.mem_ready;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            pc_q          <= '0;
            fetch_ready_q <= 1'b0;
            inst_q        <= '0;
            inst_addr_q   <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
        end else if (rdy_in) begin
            fetch_ready_q <= 1'b0;
            if (fill) valid_q[fill_idx] <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (lookup_hit) begin
                            fetch_ready_q <= 1'b1;
                            inst_q        <= data_q[req_idx];
                            inst_addr_q   <= {bus.pc[31:2], 2'b00};
                        end else begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= {bus.pc[31:2], 2'b00};
                            pc_q       <= bus.pc[31:2];
                            state_q    <= MISS_WAIT;
                        end
                    end
                end
                MISS_WAIT: begin
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                        if (!bus.rob_clear_up) begin
                            fetch_ready_q <= 1'b1;
                            inst_q        <= bus.mem_data;
                            inst_addr_q   <= {pc_q, 2'b00};
                        end
                    end else if (bus.rob_clear_up) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The in-flight read still completes and fills its line; no response is given.
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && fill) begin
            data_q[fill_idx] <= bus.mem_data;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy_in && accept) begin
            if (lookup_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else            miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    assign bus.fetch_ready = fetch_ready_q;
    assign bus.inst        = inst_q;
    assign bus.inst_addr   = inst_addr_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign dbg_state_o     = state_q;
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped instruction cache directly upstream of the instruction fetcher.
- Serves the fetcher's pc/start_fetch request with fetch_ready/inst/inst_addr.
- On a miss, fetches one 32-bit word through the memory controller's word port.
- Handles ROB clear-up by dropping any pending response; an in-flight memory read is drained safely.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 one-word lines); index = pc[INDEX_BITS+1:2].
- TAG_BITS, 30-INDEX_BITS (derived, not overridable), tag = pc[31:INDEX_BITS+2].

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous reset, active-low
- rdy_in  input  1  global ready; when low, all state frozen and all inputs ignored
- rob_clear_up  input  1  mispredict flush from ROB
- pc  input  32  fetch address from fetcher; pc[1:0] ignored
- start_fetch  input  1  level request; fetcher holds high until it sees fetch_ready
- fetch_ready  output  1  one-cycle pulse: inst/inst_addr valid
- inst  output  32  fetched instruction word
- inst_addr  output  32  address of inst (pc with [1:0] forced 0)
- mem_req  output  1  memory read request; held until mem_ready
- mem_addr  output  32  word address of request; stable while mem_req high
- mem_ready  input  1  one-cycle pulse: mem_data valid
- mem_data  input  32  returned word

Behaviour:
- Reset (rst_in low, async):
  - all valid bits cleared; state IDLE.
  - fetch_ready=0, inst=0, inst_addr=0, mem_req=0, mem_addr=0.
- States: IDLE, MISS_WAIT, DRAIN.
- IDLE:
  - A request is accepted when start_fetch=1 and rob_clear_up=0 and fetch_ready is currently 0.
  - The fetch_ready=0 condition prevents re-serving the stale pc in the cycle the fetcher drops start_fetch.
- Hit (valid[idx] && tag match):
  - Next edge: fetch_ready=1, inst=data[idx], inst_addr=pc; stay IDLE.
  - Latency 1 cycle.
- Miss:
  - Next edge: mem_req=1, mem_addr={pc[31:2],2'b00}; pc is latched internally; go MISS_WAIT.
- MISS_WAIT:
  - On mem_ready: write data/tag/valid at the latched index; mem_req=0; go IDLE.
  - Same edge: fetch_ready=1, inst=mem_data, inst_addr=latched pc.
  - Total miss latency = memory latency + 1 edge.
- fetch_ready is high for exactly one cycle, then deasserts unconditionally.
- rob_clear_up:
  - In IDLE: next-cycle fetch_ready forced 0; any lookup in that cycle is discarded.
  - In MISS_WAIT without mem_ready: go DRAIN, keep mem_req high; the in-flight read is never cancelled.
  - In MISS_WAIT with mem_ready in the same cycle: line is filled, no fetch_ready, go IDLE.
- DRAIN:
  - Wait for mem_ready; fill the line (data is correct for its address); no fetch_ready; mem_req=0; go IDLE.
  - start_fetch is ignored until IDLE; the new pc is then served normally.
- Cache contents survive rob_clear_up; only reset invalidates (no self-modifying code supported).
- Conflict miss overwrites the line unconditionally; no replacement state.
- rdy_in low: no state, output, or array changes.
  - The memory controller is likewise rdy-gated, so mem_ready cannot be lost.
- At most one outstanding memory request at any time.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined: adds outputs hit_cnt and miss_cnt (32 bits each, reset 0).
  - hit_cnt increments on each accepted hit.
  - miss_cnt increments on each accepted miss.
  - Wrap at 2^32. Requests discarded by rob_clear_up in the accept cycle are not counted.
  - Frozen when rdy_in low.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then start_fetch with pc=0x0000_0000:
  - mem_req=1, mem_addr=0 next cycle.
  - mem_ready with mem_data=0x0000_0013 -> next cycle fetch_ready=1, inst=0x13, inst_addr=0; single-cycle pulse.
- Refetch pc=0x0 after fill -> fetch_ready 1 cycle after start_fetch, inst=0x13, no mem_req. With ICACHE_STATS_EN: hit_cnt=1, miss_cnt=1.
- Conflict: fill pc=0x104, then pc=0x4 (same index 1, INDEX_BITS=6) -> miss, mem_req with mem_addr=0x4.
  - Then pc=0x104 -> miss again.
- rob_clear_up during MISS_WAIT for pc=0x40:
  - mem_req stays high; mem_ready 3 cycles later -> no fetch_ready.
  - Subsequent pc=0x40 request hits in 1 cycle.
- rob_clear_up in the same cycle as a hit lookup -> no fetch_ready next cycle.
  - New pc=0x80 next cycle is served correctly.
- rdy_in low for 5 cycles during MISS_WAIT:
  - mem_req/mem_addr unchanged, fetch_ready stays 0.
  - Completion proceeds normally after rdy_in returns high.
- Assert rst_in low mid-miss (asynchronous) -> mem_req=0 and fetch_ready=0 immediately; a prior hit address now misses.
